// File: rtl/axi_rd_4k_split_pkg.sv
// ============================================================================
// Module : axi_rd_4k_split_pkg
// Brief  : Shared page constants, FSM encoding and page-room helper.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package axi_rd_4k_split_pkg;

  localparam int PAGE_BYTES = 4096;
  localparam int PAGE_W     = 12;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  // Beats of the given size that still fit between the offset and the page end.
  function automatic logic [12:0] page_beats(input logic [PAGE_W-1:0] off,
                                             input logic [2:0]        size);
    logic [12:0] room;
    room = 13'(PAGE_BYTES) - {1'b0, off};
    return room >> size;
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi_split_pend_fifo.sv
// ============================================================================
// Module : axi_split_pend_fifo
// Brief  : 1-bit synchronous FIFO holding the last-flag of each issued sub-burst.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axi_split_pend_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     din,
  input  logic                     pop,
  output logic                     dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      cnt;
  logic             do_pop;
  logic             do_push;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign count   = cnt;
  assign dout    = mem[rd_ptr];
  // Pop is resolved first so a push into a full FIFO succeeds alongside a pop.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      mem    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

`default_nettype wire

// File: rtl/axi_rd_4k_split.sv
// ============================================================================
// Module : axi_rd_4k_split
// Brief  : Splits AXI4 AR bursts at 4 KiB pages and re-merges rlast on R.
//          Optional counters enabled by AXI_RD_SPLIT_STATS_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module axi_rd_4k_split
  import axi_rd_4k_split_pkg::*;
#(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 512,
  parameter int LEN_W      = 8,
  parameter int PEND_DEPTH = 8
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic [LEN_W-1:0]  s_axi_arlen,
  input  logic [2:0]        s_axi_arsize,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rlast,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [LEN_W-1:0]  m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast
`ifdef AXI_RD_SPLIT_STATS_EN
  ,
  output logic [31:0]       stat_req_cnt,
  output logic [31:0]       stat_split_cnt
`endif
);

  localparam int REM_W = LEN_W + 1;
  localparam int CW    = $clog2(PEND_DEPTH) + 1;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [REM_W-1:0]  rem;
  logic [2:0]        size;
  logic [LEN_W-1:0]  ar_len;
  logic              ar_valid;
  logic              s_ready;
  logic              last_flag;

  logic              s_hs;
  logic              m_hs;
  logic              r_pop;
  logic              fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [CW-1:0]     count_next;
  logic              full_next;

  logic [REM_W-1:0]  cur_cnt;
  logic [ADDR_W-1:0] ld_addr;
  logic [REM_W-1:0]  ld_rem;
  logic [2:0]        ld_size;
  logic [12:0]       ld_pb;
  logic [REM_W-1:0]  ld_cnt;

  assign s_hs  = s_axi_arvalid && s_ready;
  assign m_hs  = ar_valid && m_axi_arready;
  assign r_pop = m_axi_rvalid && s_axi_rready && m_axi_rlast && !fifo_empty;

  assign count_next = fifo_count + CW'(m_hs) - CW'(r_pop);
  assign full_next  = (count_next == CW'(PEND_DEPTH));

  // Next sub-burst: either the fresh request or what remains after the current one.
  always_comb begin
    cur_cnt = REM_W'(ar_len) + REM_W'(1);
    if (state == IDLE) begin
      ld_size = s_axi_arsize;
      ld_addr = s_axi_araddr & ~((ADDR_W'(1) << s_axi_arsize) - ADDR_W'(1));
      ld_rem  = REM_W'(s_axi_arlen) + REM_W'(1);
    end else begin
      ld_size = size;
      ld_addr = addr + (ADDR_W'(cur_cnt) << size);
      ld_rem  = rem - cur_cnt;
    end
    ld_pb  = page_beats(ld_addr[PAGE_W-1:0], ld_size);
    ld_cnt = (13'(ld_rem) < ld_pb) ? ld_rem : REM_W'(ld_pb);
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state     <= IDLE;
      s_ready   <= 1'b0;
      ar_valid  <= 1'b0;
      addr      <= '0;
      rem       <= '0;
      size      <= '0;
      ar_len    <= '0;
      last_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          s_ready <= 1'b1;
          if (s_hs) begin
            state     <= ISSUE;
            s_ready   <= 1'b0;
            addr      <= ld_addr;
            rem       <= ld_rem;
            size      <= ld_size;
            ar_len    <= LEN_W'(ld_cnt - REM_W'(1));
            last_flag <= (ld_cnt == ld_rem);
          end
        end
        ISSUE: begin
          if (m_hs) begin
            if (last_flag) begin
              state    <= IDLE;
              s_ready  <= 1'b1;
              ar_valid <= 1'b0;
            end else begin
              addr      <= ld_addr;
              rem       <= ld_rem;
              ar_len    <= LEN_W'(ld_cnt - REM_W'(1));
              last_flag <= (ld_cnt == ld_rem);
              ar_valid  <= !full_next;
            end
          end else if (!ar_valid) begin
            ar_valid <= !full_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  axi_split_pend_fifo #(
    .DEPTH (PEND_DEPTH)
  ) u_pend_fifo (
    .clk   (aclk),
    .rst_n (aresetn),
    .push  (m_hs),
    .din   (last_flag),
    .pop   (r_pop),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign s_axi_arready = s_ready;
  assign m_axi_arvalid = ar_valid;
  assign m_axi_araddr  = addr;
  assign m_axi_arlen   = ar_len;
  assign m_axi_arsize  = size;

  assign s_axi_rvalid  = m_axi_rvalid;
  assign m_axi_rready  = s_axi_rready;
  assign s_axi_rdata   = m_axi_rdata;
  assign s_axi_rresp   = m_axi_rresp;
  assign s_axi_rlast   = m_axi_rlast && fifo_head && !fifo_empty;

`ifdef AXI_RD_SPLIT_STATS_EN
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stat_req_cnt   <= '0;
      stat_split_cnt <= '0;
    end else begin
      if (s_hs)              stat_req_cnt   <= stat_req_cnt + 32'd1;
      if (m_hs && !last_flag) stat_split_cnt <= stat_split_cnt + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // R data with no sub-burst outstanding means the downstream broke protocol.
  always @(posedge aclk) begin
    if (aresetn && m_axi_rvalid) assert (!fifo_empty || fifo_full);
  end
`endif

endmodule

`default_nettype wire
